// File: rtl/getir2_pkg.sv
// getir2_pkg: shared constants and helpers for the fetch-2 stage.
//   PS_BIT_VARSAYILAN / BUYRUK_BIT_VARSAYILAN : default PC / instruction widths
//   GETIR2_DERINLIK                           : default internal FIFO depth
//   BELLEK_BASLANGIC                          : reset PC of the core
//   sayac_bit(d)                              : width of a 0..d occupancy counter
package getir2_pkg;
  localparam int          PS_BIT_VARSAYILAN     = 32;
  localparam int          BUYRUK_BIT_VARSAYILAN = 32;
  localparam int          GETIR2_DERINLIK       = 4;
  localparam logic [31:0] BELLEK_BASLANGIC      = 32'h8000_0000;

  // Counter width able to hold 0..d inclusive.
  function automatic int sayac_bit(input int d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/getir2_if.sv
// getir2_if: fetch-1 / L1B / decode signals seen by the fetch-2 stage.
//   slave  : getir2 side (PC and word in, pair out)
//   master : environment side (fetch-1, L1B and decode models)
// GETIR2_HATA_DENETIM_EN adds l1b_hata_i / coz_hata_o.
interface getir2_if #(
  parameter int PS_BIT     = 32,
  parameter int BUYRUK_BIT = 32
);
  logic                  g1_istek_yapildi_i;
  logic [PS_BIT-1:0]     g1_ps_i;
  logic                  g1_ps_gecerli_i;
  logic                  g1_ps_hazir_o;
  logic [BUYRUK_BIT-1:0] l1b_buyruk_i;
  logic                  l1b_buyruk_gecerli_i;
  logic                  cek_bosalt_i;
  logic [PS_BIT-1:0]     coz_ps_o;
  logic [BUYRUK_BIT-1:0] coz_buyruk_o;
  logic                  coz_gecerli_o;
  logic                  coz_hazir_i;
`ifdef GETIR2_HATA_DENETIM_EN
  logic                  l1b_hata_i;
  logic                  coz_hata_o;
`endif

  modport slave (
    input  g1_istek_yapildi_i, g1_ps_i, g1_ps_gecerli_i,
    input  l1b_buyruk_i, l1b_buyruk_gecerli_i, cek_bosalt_i, coz_hazir_i,
`ifdef GETIR2_HATA_DENETIM_EN
    input  l1b_hata_i,
    output coz_hata_o,
`endif
    output g1_ps_hazir_o, coz_ps_o, coz_buyruk_o, coz_gecerli_o
  );

  modport master (
    output g1_istek_yapildi_i, g1_ps_i, g1_ps_gecerli_i,
    output l1b_buyruk_i, l1b_buyruk_gecerli_i, cek_bosalt_i, coz_hazir_i,
`ifdef GETIR2_HATA_DENETIM_EN
    output l1b_hata_i,
    input  coz_hata_o,
`endif
    input  g1_ps_hazir_o, coz_ps_o, coz_buyruk_o, coz_gecerli_o
  );
endinterface

// File: rtl/getir2_fifo.sv
// getir2_fifo: synchronous FIFO with registered storage and a head that is
// read straight from storage (no combinational path from the write side).
//   clk_i, rst_i  : clock, async active-high reset (storage cleared too)
//   temizle_i     : synchronous clear, wins over push/pop
//   yaz_i/yaz_veri_i : push
//   oku_i         : pop (caller only pops when non-empty)
//   bas_o         : head entry
//   sayac_o, bos_o, dolu_o : occupancy, empty, full
module getir2_fifo
  import getir2_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    temizle_i,
  input  logic                    yaz_i,
  input  logic [W-1:0]            yaz_veri_i,
  input  logic                    oku_i,
  output logic [W-1:0]            bas_o,
  output logic [sayac_bit(D)-1:0] sayac_o,
  output logic                    bos_o,
  output logic                    dolu_o
);
  localparam int AW = $clog2(D);
  localparam int CW = sayac_bit(D);

  logic [D-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]       yaz_ptr_q, yaz_ptr_d;
  logic [AW-1:0]       oku_ptr_q, oku_ptr_d;
  logic [CW-1:0]       sayac_q, sayac_d;

  always_comb begin
    mem_d     = mem_q;
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayac_d   = sayac_q;
    if (temizle_i) begin
      yaz_ptr_d = '0;
      oku_ptr_d = '0;
      sayac_d   = '0;
    end else begin
      if (yaz_i) begin
        mem_d[yaz_ptr_q] = yaz_veri_i;
        yaz_ptr_d        = yaz_ptr_q + AW'(1);
      end
      if (oku_i) oku_ptr_d = oku_ptr_q + AW'(1);
      sayac_d = sayac_q + CW'(yaz_i) - CW'(oku_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q     <= '0;
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayac_q   <= '0;
    end else begin
      mem_q     <= mem_d;
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayac_q   <= sayac_d;
    end
  end

  assign bas_o   = mem_q[oku_ptr_q];
  assign sayac_o = sayac_q;
  assign bos_o   = (sayac_q == '0);
  assign dolu_o  = (sayac_q == CW'(D));

  a_bos_okuma: assert property (@(posedge clk_i) disable iff (rst_i)
    !(oku_i && bos_o && !temizle_i))
    else $fatal(1, "getir2_fifo: pop while empty");
endmodule

// File: rtl/getir2.sv
// getir2: fetch stage 2. Pairs PCs issued by fetch-1 with the in-order words
// returned by L1B and hands the pairs to decode over valid/ready.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : g1_* PC input with ready, l1b_* response input (never
//                  stalled), cek_bosalt_i redirect, coz_* pair output
// Optional macro GETIR2_HATA_DENETIM_EN: stores l1b_hata_i with each word and
// drives coz_hata_o (stored fault or misaligned PC).
module getir2
  import getir2_pkg::*;
#(
  parameter int PS_BIT     = PS_BIT_VARSAYILAN,
  parameter int BUYRUK_BIT = BUYRUK_BIT_VARSAYILAN,
  parameter int DERINLIK   = GETIR2_DERINLIK
) (
  input  logic     clk_i,
  input  logic     rst_i,
  getir2_if.slave  bus
);
  localparam int CW = sayac_bit(DERINLIK);
`ifdef GETIR2_HATA_DENETIM_EN
  localparam int BW = BUYRUK_BIT + 1;
`else
  localparam int BW = BUYRUK_BIT;
`endif

  logic [CW-1:0] ucusta_q, ucusta_d;
  logic [CW-1:0] atilacak_q, atilacak_d;
  // One extra bit so an out-of-range update is visible before truncation.
  logic [CW:0]   ucusta_gen, atilacak_gen;

  logic              ps_yaz, b_yaz, cift_al;
  logic [PS_BIT-1:0] ps_bas;
  logic [BW-1:0]     b_bas, b_yaz_veri;
  logic [CW-1:0]     ps_sayac, b_sayac;
  logic              ps_bos, ps_dolu, b_bos, b_dolu;
  logic [CW+1:0]     doluluk;
  logic              hazir, gecerli;
  logic              yanit, yanit_at, yanit_say;

  assign yanit     = bus.l1b_buyruk_gecerli_i;
  assign yanit_at  = yanit && (atilacak_q != '0);
  assign yanit_say = yanit && !yanit_at;

  // Ready looks only at registered counts. Two slots of headroom: fetch-1
  // may hold one accepted-but-unpresented PC and have one more in flight.
  assign doluluk = {2'b00, ucusta_q} + {2'b00, ps_sayac} + {2'b00, b_sayac};
  assign hazir   = !rst_i && !bus.cek_bosalt_i && (doluluk <= (CW+2)'(DERINLIK-2));

  assign ps_yaz  = bus.g1_ps_gecerli_i && hazir;
  assign b_yaz   = yanit_say && !bus.cek_bosalt_i;
  assign gecerli = !ps_bos && !b_bos && !bus.cek_bosalt_i;
  assign cift_al = gecerli && bus.coz_hazir_i;

`ifdef GETIR2_HATA_DENETIM_EN
  assign b_yaz_veri = {bus.l1b_hata_i, bus.l1b_buyruk_i};
`else
  assign b_yaz_veri = bus.l1b_buyruk_i;
`endif

  getir2_fifo #(.W(PS_BIT), .D(DERINLIK)) u_ps_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .temizle_i  (bus.cek_bosalt_i),
    .yaz_i      (ps_yaz),
    .yaz_veri_i (bus.g1_ps_i),
    .oku_i      (cift_al),
    .bas_o      (ps_bas),
    .sayac_o    (ps_sayac),
    .bos_o      (ps_bos),
    .dolu_o     (ps_dolu)
  );

  getir2_fifo #(.W(BW), .D(DERINLIK)) u_buyruk_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .temizle_i  (bus.cek_bosalt_i),
    .yaz_i      (b_yaz),
    .yaz_veri_i (b_yaz_veri),
    .oku_i      (cift_al),
    .bas_o      (b_bas),
    .sayac_o    (b_sayac),
    .bos_o      (b_bos),
    .dolu_o     (b_dolu)
  );

  always_comb begin
    ucusta_gen   = {1'b0, ucusta_q} + (CW+1)'(bus.g1_istek_yapildi_i) - (CW+1)'(yanit_say);
    atilacak_gen = {1'b0, atilacak_q} - (CW+1)'(yanit_at);
    if (bus.cek_bosalt_i) begin
      // Everything still in flight becomes garbage. This cycle's response
      // consumes one of those, whether it was already owed to atilacak or
      // counted in ucusta. A request issued now belongs to the new stream.
      atilacak_gen = {1'b0, atilacak_q} + {1'b0, ucusta_q} - (CW+1)'(yanit);
      ucusta_gen   = (CW+1)'(bus.g1_istek_yapildi_i);
    end
    ucusta_d   = ucusta_gen[CW-1:0];
    atilacak_d = atilacak_gen[CW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ucusta_q   <= '0;
      atilacak_q <= '0;
    end else begin
      ucusta_q   <= ucusta_d;
      atilacak_q <= atilacak_d;
    end
  end

  assign bus.g1_ps_hazir_o = hazir;
  assign bus.coz_gecerli_o = gecerli;
  assign bus.coz_ps_o      = ps_bas;
  assign bus.coz_buyruk_o  = b_bas[BUYRUK_BIT-1:0];
`ifdef GETIR2_HATA_DENETIM_EN
  assign bus.coz_hata_o    = b_bas[BUYRUK_BIT] || (ps_bas[1:0] != 2'b00);
`endif

  a_ucusta: assert property (@(posedge clk_i) disable iff (rst_i) !ucusta_gen[CW])
    else $fatal(1, "getir2: ucusta out of range");
  a_atilacak: assert property (@(posedge clk_i) disable iff (rst_i) !atilacak_gen[CW])
    else $fatal(1, "getir2: atilacak out of range");
  a_b_tasma: assert property (@(posedge clk_i) disable iff (rst_i) !(b_yaz && b_dolu && !cift_al))
    else $fatal(1, "getir2: buyruk fifo overflow");
  a_ps_tasma: assert property (@(posedge clk_i) disable iff (rst_i) !(ps_yaz && ps_dolu && !cift_al))
    else $fatal(1, "getir2: ps fifo overflow");
endmodule

// File: doc/getir2.md
Name: getir2

Overview:
- Fetch stage 2. Sits directly downstream of the fetch-1 stage (PC generator / L1B requester) and upstream of the decode stage (coz).
- Accepts issued PCs from fetch-1 and in-order instruction words returned by the L1 instruction cache (L1B). Pairs each word with its PC and presents the pair to decode over a valid/ready handshake.
- Absorbs L1B responses, which cannot be back-pressured. Discards in-flight responses after a core redirect/flush.

Parameters:
- PS_BIT, 32, PC width (matches `PS_BIT in sabitler.vh).
- BUYRUK_BIT, 32, instruction word width.
- DERINLIK, 4, entries in each internal FIFO; power of 2, minimum 4.

Ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- g1_istek_yapildi_i  in  1  fetch-1 had an L1B request accepted this cycle.
- g1_ps_i  in  PS_BIT  PC of a request already accepted by L1B.
- g1_ps_gecerli_i  in  1  g1_ps_i valid.
- g1_ps_hazir_o  out  1  getir2 accepts g1_ps_i this cycle.
- l1b_buyruk_i  in  BUYRUK_BIT  returned instruction word.
- l1b_buyruk_gecerli_i  in  1  response valid; always accepted, never stalled.
- cek_bosalt_i  in  1  core redirect; asserted in the same cycle as fetch-1's cek_ps_gecerli_i.
- coz_ps_o  out  PS_BIT  PC to decode.
- coz_buyruk_o  out  BUYRUK_BIT  instruction to decode.
- coz_gecerli_o  out  1  pair valid.
- coz_hazir_i  in  1  decode accepts.
- l1b_hata_i  in  1  L1B access fault (only with GETIR2_HATA_DENETIM_EN).
- coz_hata_o  out  1  fetch fault flag (only with GETIR2_HATA_DENETIM_EN).

Behaviour:
- Reset (async, rst_i=1): both FIFOs empty; ucusta=0; atilacak=0; g1_ps_hazir_o=0 while rst_i is high; coz_gecerli_o=0; coz_ps_o=0; coz_buyruk_o=0; coz_hata_o=0.
- State:
  - ps FIFO (DERINLIK x PS_BIT).
  - buyruk FIFO (DERINLIK x BUYRUK_BIT, +1 fault bit with macro).
  - ucusta: count of issued-but-unreturned requests, width clog2(DERINLIK)+1.
  - atilacak: responses still to be dropped, same width.
- ucusta update: +1 on g1_istek_yapildi_i; -1 on any l1b_buyruk_gecerli_i that is not counted against atilacak; both in one cycle means no change.
- Ready: g1_ps_hazir_o = !rst_i && !cek_bosalt_i && (ucusta + buyruk_sayac + ps_sayac <= DERINLIK-2). The 2-entry headroom covers fetch-1's held PC plus one request in flight. Computed from registered counts only, with no combinational path from g1_ps_gecerli_i.
- PC push: on g1_ps_gecerli_i && g1_ps_hazir_o.
- Response routing:
  - If atilacak>0: the response is discarded and atilacak decrements.
  - Otherwise: the response is pushed into the buyruk FIFO.
  - The buyruk FIFO never overflows by construction; overflow in simulation is a fatal assertion.
- Output:
  - coz_gecerli_o = ps FIFO non-empty && buyruk FIFO non-empty && !cek_bosalt_i.
  - coz_ps_o and coz_buyruk_o come from the FIFO heads, registered storage only.
  - Both heads pop on coz_gecerli_o && coz_hazir_i.
  - Latency: a response arriving in cycle t with its PC already queued is presented at t+1. Sustained throughput is 1 pair per cycle.
- Output hold: while coz_gecerli_o=1 and coz_hazir_i=0, coz_ps_o and coz_buyruk_o stay stable.
- Simultaneous push and pop on a full FIFO is legal; push on a full FIFO without a pop is impossible by the ready rule.
- Flush (cek_bosalt_i=1):
  - Both FIFOs clear at the next edge.
  - atilacak_next = atilacak + ucusta - (this cycle's response when atilacak==0 ? 1 : 0), or -1 if this cycle's response is itself dropped.
  - ucusta_next = g1_istek_yapildi_i ? 1 : 0. A request issued in the flush cycle belongs to the new stream.
  - No PC accepted, no output handshake.
- Back-to-back flushes accumulate into atilacak. Counters wrap never; saturation or underflow is a fatal assertion.

Optional Feature:
- Macro: GETIR2_HATA_DENETIM_EN.
- With the macro:
  - l1b_hata_i is stored alongside each word.
  - coz_hata_o = stored fault || (coz_ps_o[1:0] != 0), valid with coz_gecerli_o.
  - A faulted pair is still delivered once; decode raises the exception.
- Without the macro: the l1b_hata_i and coz_hata_o ports and the fault storage do not exist.

Decomposition:
- sabitler.vh: PS_BIT, BUYRUK_BIT, HIGH/LOW, BELLEK_BASLANGIC (already shared); add GETIR2_DERINLIK default.
- One sub-module, getir2_fifo:
  - Parameterised width/depth synchronous FIFO with async active-high reset and a synchronous clear input.
  - Exposes sayac, bos, dolu; instantiated twice.

Test Plan:
- Reset mid-stream: rst_i pulsed with 3 pairs queued -> all outputs 0 in the same cycle; after release coz_gecerli_o=0 and g1_ps_hazir_o=1.
- Streaming: PCs 0x80000000..0x8000000C with words returned the cycle after each PC, coz_hazir_i=1 -> 4 pairs, 1/cycle, first pair 1 cycle after its word, PC and word matched.
- Backpressure: coz_hazir_i=0 for 10 cycles while feeding -> g1_ps_hazir_o drops at ucusta+buyruk+ps=DERINLIK-1, no overflow; outputs hold stable; release drains in order.
- Flush with 2 in flight: cek_bosalt_i with ucusta=2, new request at 0x80000100 issued in the same cycle -> next 2 responses dropped; 3rd response paired with 0x80000100.
- Flush coincident with a response and an output handshake attempt: coz_gecerli_o=0 that cycle; atilacak = ucusta-1; no stale pair ever emitted.
- Macro on: l1b_hata_i=1 on the 2nd word, and PC 0x80000002 -> coz_hata_o=1 on exactly those pairs, 0 otherwise.
